// File: rtl/lbp_pkg.sv
// Shared types and constants for the streaming local-binary-pattern engine.
// Holds the FSM state enum, code bit positions and the address width helper.
package lbp_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StFlush,
    StDone
  } state_e;

  // Bit positions of each neighbour inside the 8-bit code.
  localparam int unsigned BitTl = 0;
  localparam int unsigned BitT  = 1;
  localparam int unsigned BitTr = 2;
  localparam int unsigned BitL  = 3;
  localparam int unsigned BitR  = 4;
  localparam int unsigned BitBl = 5;
  localparam int unsigned BitB  = 6;
  localparam int unsigned BitBr = 7;

  // Address is {row, col}, so its width is the sum of both index widths.
  function automatic int unsigned addr_w(input int unsigned img_w, input int unsigned img_h);
    return $clog2(img_w) + $clog2(img_h);
  endfunction

endpackage

// File: rtl/lbp_stream_if.sv
// Pixel fetch and result write bundle of lbp_stream.
// The engine is the master; memory and result sink sit on the slave side.
interface lbp_stream_if #(
  parameter int unsigned ADDR_W = 14,
  parameter int unsigned PIX_W  = 8
);
  logic              gray_req;
  logic              gray_ready;
  logic [ADDR_W-1:0] gray_addr;
  logic [PIX_W-1:0]  gray_data;
  logic              lbp_valid;
  logic [ADDR_W-1:0] lbp_addr;
  logic [7:0]        lbp_data;
  logic              finish;

  modport master (
    output gray_req, gray_addr, lbp_valid, lbp_addr, lbp_data, finish,
    input  gray_ready, gray_data
  );

  modport slave (
    input  gray_req, gray_addr, lbp_valid, lbp_addr, lbp_data, finish,
    output gray_ready, gray_data
  );
endinterface

// File: rtl/lbp_line_buf.sv
// Two-row pixel delay line: row1_o is the pixel one row above pix_i, row2_o two rows above.
// Advances by one column on every shift.
module lbp_line_buf #(
  parameter int unsigned IMG_W = 128,
  parameter int unsigned PIX_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             shift_i,
  input  logic [PIX_W-1:0] pix_i,
  output logic [PIX_W-1:0] row1_o,
  output logic [PIX_W-1:0] row2_o
);
  localparam int unsigned ColW = $clog2(IMG_W);

  logic [PIX_W-1:0] row1_q [IMG_W];
  logic [PIX_W-1:0] row2_q [IMG_W];
  logic [ColW-1:0]  col_q;

  assign row1_o = row1_q[col_q];
  assign row2_o = row2_q[col_q];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col_q <= '0;
      for (int i = 0; i < int'(IMG_W); i++) begin
        row1_q[i] <= '0;
        row2_q[i] <= '0;
      end
    end else if (shift_i) begin
      row1_q[col_q] <= pix_i;
      row2_q[col_q] <= row1_q[col_q];
      col_q         <= col_q + ColW'(1);
    end
  end

endmodule

// File: rtl/lbp_stream.sv
// Raster-order LBP engine: fetches each grey pixel once and writes one 8-bit code per centre.
// Define LBP_BORDER_EN to also emit border pixels (code 0) and flush the trailing results.
module lbp_stream
  import lbp_pkg::*;
#(
  parameter int unsigned IMG_W = 128,
  parameter int unsigned IMG_H = 128,
  parameter int unsigned PIX_W = 8
) (
  input  logic         clk,
  input  logic         reset,
  lbp_stream_if.master bus
);
  localparam int unsigned ADDR_W = addr_w(IMG_W, IMG_H);
  localparam int unsigned ColW   = $clog2(IMG_W);
  localparam int unsigned RowW   = ADDR_W - ColW;
  localparam int unsigned CntW   = ADDR_W + 1;

  localparam logic [CntW-1:0]   NumPix  = CntW'(IMG_W * IMG_H);
  localparam logic [CntW-1:0]   LastPix = CntW'(IMG_W * IMG_H - 1);
  localparam logic [ADDR_W-1:0] Lag     = ADDR_W'(IMG_W + 1);
  localparam logic [RowW-1:0]   RowLast = RowW'(IMG_H - 1);
  localparam logic [ColW-1:0]   ColLast = ColW'(IMG_W - 1);

`ifdef LBP_BORDER_EN
  localparam logic [CntW-1:0] LagCnt    = CntW'(IMG_W + 1);
  localparam logic [CntW-1:0] LastFlush = CntW'(IMG_W * IMG_H + IMG_W);
  localparam state_e          AfterRun  = StFlush;
`else
  localparam state_e          AfterRun  = StDone;
`endif

  state_e            state_q;
  logic [CntW-1:0]   fetch_cnt_q;
  logic [CntW-1:0]   cap_cnt_q;
  logic              cap_pend_q;
  logic              valid_q;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        data_q;
  logic              finish_q;

  logic [PIX_W-1:0]  win_q [3][2];
  logic [PIX_W-1:0]  win   [3][3];
  logic [PIX_W-1:0]  row1, row2;

  logic              accept, capture, flushing, flush_last, emit, interior;
  logic [ADDR_W-1:0] ctr_addr;
  logic [RowW-1:0]   ctr_row;
  logic [ColW-1:0]   ctr_col;
  logic [7:0]        code, emit_data;

  assign bus.gray_req  = (state_q == StRun) && (fetch_cnt_q != NumPix);
  assign bus.gray_addr = fetch_cnt_q[ADDR_W-1:0];
  assign bus.lbp_valid = valid_q;
  assign bus.lbp_addr  = addr_q;
  assign bus.lbp_data  = data_q;
  assign bus.finish    = finish_q;

  assign accept  = bus.gray_req && bus.gray_ready;
  assign capture = cap_pend_q;

  lbp_line_buf #(
    .IMG_W(IMG_W),
    .PIX_W(PIX_W)
  ) u_line_buf (
    .clk    (clk),
    .reset  (reset),
    .shift_i(capture),
    .pix_i  (bus.gray_data),
    .row1_o (row1),
    .row2_o (row2)
  );

  // Right-hand column is live so the code can be registered on the capture edge itself.
  always_comb begin
    for (int r = 0; r < 3; r++) begin
      win[r][0] = win_q[r][0];
      win[r][1] = win_q[r][1];
    end
    win[0][2] = row2;
    win[1][2] = row1;
    win[2][2] = bus.gray_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < 3; r++) begin
        win_q[r][0] <= '0;
        win_q[r][1] <= '0;
      end
    end else if (capture) begin
      for (int r = 0; r < 3; r++) begin
        win_q[r][0] <= win[r][1];
        win_q[r][1] <= win[r][2];
      end
    end
  end

  always_comb begin
    code        = '0;
    code[BitTl] = win[0][0] >= win[1][1];
    code[BitT]  = win[0][1] >= win[1][1];
    code[BitTr] = win[0][2] >= win[1][1];
    code[BitL]  = win[1][0] >= win[1][1];
    code[BitR]  = win[1][2] >= win[1][1];
    code[BitBl] = win[2][0] >= win[1][1];
    code[BitB]  = win[2][1] >= win[1][1];
    code[BitBr] = win[2][2] >= win[1][1];
  end

  // Centre trails the captured pixel by one row plus one column; wrapped columns land on borders.
  assign ctr_addr = cap_cnt_q[ADDR_W-1:0] - Lag;
  assign ctr_row  = ctr_addr[ADDR_W-1:ColW];
  assign ctr_col  = ctr_addr[ColW-1:0];
  assign interior = (ctr_row != '0) && (ctr_row != RowLast) &&
                    (ctr_col != '0) && (ctr_col != ColLast);

`ifdef LBP_BORDER_EN
  assign flushing   = (state_q == StFlush);
  assign flush_last = flushing && (cap_cnt_q == LastFlush);
  assign emit       = flushing || (capture && (cap_cnt_q >= LagCnt));
  assign emit_data  = interior ? code : 8'h00;
`else
  assign flushing   = 1'b0;
  assign flush_last = 1'b1;
  assign emit       = capture && interior;
  assign emit_data  = code;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      fetch_cnt_q <= '0;
      cap_cnt_q   <= '0;
      cap_pend_q  <= 1'b0;
      valid_q     <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      finish_q    <= 1'b0;
    end else begin
      cap_pend_q <= accept;
      if (accept) begin
        fetch_cnt_q <= fetch_cnt_q + CntW'(1);
      end
      if (capture || flushing) begin
        cap_cnt_q <= cap_cnt_q + CntW'(1);
      end
      valid_q  <= emit;
      addr_q   <= emit ? ctr_addr : '0;
      data_q   <= emit ? emit_data : '0;
      finish_q <= (state_q == StDone);
      unique case (state_q)
        StIdle:  state_q <= StRun;
        StRun:   if (capture && (cap_cnt_q == LastPix)) state_q <= AfterRun;
        StFlush: if (flush_last) state_q <= StDone;
        StDone:  state_q <= StDone;
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_lbp_stream.sv
// Directed bench for lbp_stream on a 16x8 image with 10-bit pixels.
// Compares each emitted code against a neighbourhood model and hand-derived constants.
module tb_lbp_stream;
  import lbp_pkg::*;

  localparam int W  = 16;
  localparam int H  = 8;
  localparam int PW = 10;
  localparam int AW = addr_w(W, H);
  localparam int N  = W * H;

  typedef struct {
    int            cyc;
    logic          req;
    logic          rdy;
    logic [AW-1:0] addr;
    logic          vld;
    logic [AW-1:0] laddr;
    logic [7:0]    ldata;
    logic          fin;
  } tr_t;

  logic          clk   = 1'b0;
  logic          reset = 1'b1;
  logic          rdy_tgl = 1'b0;
  int            rdy_mode = 0;
  int            cyc = 0;
  int            n_cmp = 0;
  int            n_fail = 0;
  logic [PW-1:0] img [N];
  tr_t           trace [$];

  always #5 clk = ~clk;

  lbp_stream_if #(.ADDR_W(AW), .PIX_W(PW)) bus ();

  lbp_stream #(
    .IMG_W(W),
    .IMG_H(H),
    .PIX_W(PW)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Ready changes just after the edge so it is stable for the whole next cycle.
  always @(posedge clk) begin
    #2;
    rdy_tgl = ~rdy_tgl;
    bus.gray_ready = (rdy_mode == 0) ? 1'b1 :
                     (rdy_mode == 1) ? rdy_tgl : 1'($urandom_range(0, 1));
  end

  // Memory: data valid one cycle after an accepted fetch, garbage otherwise.
  always @(posedge clk) begin
    if (bus.gray_req === 1'b1 && bus.gray_ready === 1'b1) bus.gray_data <= img[bus.gray_addr];
    else bus.gray_data <= PW'($urandom);
  end

  always @(negedge clk) begin
    tr_t e;
    e.cyc = cyc; e.req = bus.gray_req; e.rdy = bus.gray_ready; e.addr = bus.gray_addr;
    e.vld = bus.lbp_valid; e.laddr = bus.lbp_addr; e.ldata = bus.lbp_data; e.fin = bus.finish;
    trace.push_back(e);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit is_interior(input int r, input int c);
    return (r > 0) && (r < H - 1) && (c > 0) && (c < W - 1);
  endfunction

  function automatic bit emitted(input int r, input int c);
`ifdef LBP_BORDER_EN
    return 1'b1;
`else
    return is_interior(r, c);
`endif
  endfunction

  // Neighbour order: top row left-to-right, then left, right, then bottom row.
  function automatic logic [7:0] model_code(input int r, input int c);
    logic [7:0] code = '0;
    int k = 0;
    if (!is_interior(r, c)) return 8'h00;
    for (int dr = -1; dr <= 1; dr++) begin
      for (int dc = -1; dc <= 1; dc++) begin
        if (!(dr == 0 && dc == 0)) begin
          code[k] = (img[(r + dr) * W + c + dc] >= img[r * W + c]);
          k++;
        end
      end
    end
    return code;
  endfunction

  function automatic logic [7:0] find_code(input int t0, input int a);
    foreach (trace[i]) begin
      if (trace[i].cyc >= t0 && trace[i].vld === 1'b1 && trace[i].laddr == AW'(a))
        return trace[i].ldata;
    end
    return 8'hxx;
  endfunction

  task automatic apply_reset(output int t0);
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    t0 = cyc + 1;
  endtask

  task automatic wait_finish(input string tag);
    int n = 0;
    while (bus.finish !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, " finish reached"}, 32'(bus.finish), 1);
    repeat (4) @(negedge clk);
  endtask

  task automatic check_frame(input int t0, input string tag, input bit uniform);
    logic [AW-1:0] r_addr [$];
    logic [7:0]    r_data [$];
    int            r_cyc  [$];
    int acc = 0, acc_bad = 0, hold_bad = 0, last_vld = -1, first_fin = -1, k = 0;
    bit have_prev = 1'b0;
    tr_t prev;
    logic [7:0] exp;
    foreach (trace[i]) begin
      if (trace[i].cyc < t0) continue;
      if (have_prev && prev.req === 1'b1 && prev.rdy === 1'b0 && trace[i].addr !== prev.addr)
        hold_bad++;
      if (trace[i].req === 1'b1 && trace[i].rdy === 1'b1) begin
        if (trace[i].addr !== AW'(acc)) acc_bad++;
        acc++;
      end
      if (trace[i].vld !== 1'b0) begin
        r_addr.push_back(trace[i].laddr);
        r_data.push_back(trace[i].ldata);
        r_cyc.push_back(trace[i].cyc);
        last_vld = trace[i].cyc;
      end
      if (trace[i].fin === 1'b1 && first_fin < 0) first_fin = trace[i].cyc;
      prev = trace[i];
      have_prev = 1'b1;
    end
    chk({tag, " fetch count"}, acc, N);
    chk({tag, " fetch order errors"}, acc_bad, 0);
    chk({tag, " addr hold errors"}, hold_bad, 0);
    for (int p = 0; p < N; p++) begin
      if (emitted(p / W, p % W)) begin
        if (k < r_addr.size()) begin
          exp = uniform ? (is_interior(p / W, p % W) ? 8'hFF : 8'h00) : model_code(p / W, p % W);
          chk({tag, $sformatf(" addr #%0d", k)}, r_addr[k], p);
          chk({tag, $sformatf(" code @%0d", p)}, r_data[k], exp);
        end
        k++;
      end
    end
    chk({tag, " result count"}, r_addr.size(), k);
    chk({tag, " finish lag"}, first_fin, last_vld + 1);
`ifdef LBP_BORDER_EN
    if (r_cyc.size() > W)
      chk({tag, " flush burst"}, r_cyc[r_cyc.size() - 1] - r_cyc[r_cyc.size() - 1 - W], W);
`endif
  endtask

  initial begin
    int t0;
    int n;
    for (int i = 0; i < N; i++) img[i] = '0;
    repeat (2) @(negedge clk);
    chk("reset gray_req", bus.gray_req, 0);
    chk("reset gray_addr", bus.gray_addr, 0);
    chk("reset lbp_valid", bus.lbp_valid, 0);
    chk("reset lbp_addr", bus.lbp_addr, 0);
    chk("reset lbp_data", bus.lbp_data, 0);
    chk("reset finish", bus.finish, 0);

    // Flat image, ready tied high: every interior code is 0xFF.
    for (int i = 0; i < N; i++) img[i] = PW'(50);
    rdy_mode = 0;
    apply_reset(t0);
    wait_finish("flat");
    check_frame(t0, "flat", 1'b1);
    chk("flat finish held", bus.finish, 1);
    chk("flat req idle", bus.gray_req, 0);

    // Ramp around (5,5) and a 10-bit centre at (2,10).
    for (int i = 0; i < N; i++) img[i] = '0;
    for (int dr = -1; dr <= 1; dr++)
      for (int dc = -1; dc <= 1; dc++) begin
        img[(5 + dr) * W + 5 + dc]  = PW'(92 + 2 * ((dr + 1) * 3 + dc + 1));
        img[(2 + dr) * W + 10 + dc] = PW'(44);
      end
    img[2 * W + 10] = PW'(300);
    img[3 * W + 11] = PW'(512);
    apply_reset(t0);
    wait_finish("ramp");
    check_frame(t0, "ramp", 1'b0);
    chk("ramp code (5,5)", find_code(t0, 5 * W + 5), 8'hF0);
    chk("ramp code (2,10) 10-bit", find_code(t0, 2 * W + 10), 8'h80);

    // Random image, ready toggling every cycle.
    for (int i = 0; i < N; i++) img[i] = PW'($urandom);
    rdy_mode = 1;
    apply_reset(t0);
    wait_finish("toggle");
    check_frame(t0, "toggle", 1'b0);

    // Random ready, reset pulsed mid-frame at pixel 70.
    for (int i = 0; i < N; i++) img[i] = PW'($urandom);
    rdy_mode = 2;
    apply_reset(t0);
    n = 0;
    while (!(bus.gray_req === 1'b1 && bus.gray_ready === 1'b1 && bus.gray_addr == AW'(70))
           && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("abort reached pixel 70", bus.gray_addr, 70);
    reset = 1'b1;
    #1;
    chk("abort gray_req", bus.gray_req, 0);
    chk("abort gray_addr", bus.gray_addr, 0);
    chk("abort lbp_valid", bus.lbp_valid, 0);
    chk("abort lbp_data", bus.lbp_data, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    t0 = cyc + 1;
    wait_finish("restart");
    check_frame(t0, "restart", 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: bench did not reach its summary");
    $fatal(1, "watchdog expired");
  end

endmodule
